// File: rtl/raster_pkg.sv
// Shared definitions for the scanline triangle filler.
//   DEF_COORD_WIDTH : default signed vertex coordinate width
//   coord_t         : signed vertex coordinate at the default width
//   fill_state_t    : top-level fill sequencer states
//   clamp_int       : clamps a value into [lo, hi]
package raster_pkg;

  localparam int DEF_COORD_WIDTH = 16;

  typedef logic signed [DEF_COORD_WIDTH-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SORT,
    ST_INIT_EDGES,
    ST_WALK_ROW,
    ST_EMIT_SPAN,
    ST_SWITCH_EDGE,
    ST_FINISH
  } fill_state_t;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/bresenham_edge_span.sv
// Walks one edge (xa,ya)->(xb,yb), ya <= yb, one Bresenham step per cycle,
// one scanline per advance request.
//   clk_in, rst_in  : clock, synchronous active-high reset
//   start           : load endpoints and reset the walk to (xa,ya)
//   advance         : walk the current row from the current pixel
//   stall           : freeze stepping for this cycle
//   row_done        : min_x/max_x hold the finished row (held until advance/start)
//   min_x, max_x    : x extent of this edge on the row just walked
//   last_row        : the edge ended on the row just walked
module bresenham_edge_span
  import raster_pkg::*;
#(
  parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic signed [COORD_WIDTH-1:0] xa,
  input  logic signed [COORD_WIDTH-1:0] ya,
  input  logic signed [COORD_WIDTH-1:0] xb,
  input  logic signed [COORD_WIDTH-1:0] yb,
  input  logic                          advance,
  input  logic                          stall,
  output logic                          row_done,
  output logic signed [COORD_WIDTH+1:0] min_x,
  output logic signed [COORD_WIDTH+1:0] max_x,
  output logic                          last_row
);

  localparam int AW = COORD_WIDTH + 2;
  localparam logic signed [AW-1:0] ONE = AW'(1);

  logic signed [AW-1:0] cx, cy, ex, ey, dx, dy, err;
  logic                 x_neg, walking;
  logic signed [AW-1:0] xa_w, ya_w, xb_w, yb_w, ddx, ddy, abs_dx, neg_dy;
  logic signed [AW-1:0] e2, nx, ny, nerr;
  logic                 y_step, at_end;

  assign xa_w   = AW'(xa);
  assign ya_w   = AW'(ya);
  assign xb_w   = AW'(xb);
  assign yb_w   = AW'(yb);
  assign ddx    = xb_w - xa_w;
  assign ddy    = yb_w - ya_w;
  assign abs_dx = (ddx < 0) ? -ddx : ddx;
  assign neg_dy = (ddy < 0) ? ddy : -ddy;
  assign at_end = (cx == ex) && (cy == ey);

  // One Bresenham step from the current pixel.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    e2     = err <<< 1;
    nx     = cx;
    ny     = cy;
    nerr   = err;
    y_step = 1'b0;
    if (e2 >= dy) begin
      nerr = nerr + dy;
      nx   = x_neg ? cx - ONE : cx + ONE;
    end
    if (e2 <= dx) begin
      nerr   = nerr + dx;
      ny     = cy + ONE;
      y_step = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cx       <= '0;
      cy       <= '0;
      ex       <= '0;
      ey       <= '0;
      dx       <= '0;
      dy       <= '0;
      err      <= '0;
      x_neg    <= 1'b0;
      walking  <= 1'b0;
      row_done <= 1'b0;
      last_row <= 1'b0;
      min_x    <= '0;
      max_x    <= '0;
    end else if (start) begin
      cx       <= xa_w;
      cy       <= ya_w;
      ex       <= xb_w;
      ey       <= yb_w;
      dx       <= abs_dx;
      dy       <= neg_dy;
      err      <= abs_dx + neg_dy;
      x_neg    <= (ddx < 0);
      walking  <= 1'b0;
      row_done <= 1'b0;
      last_row <= 1'b0;
      min_x    <= xa_w;
      max_x    <= xa_w;
    end else if (advance) begin
      walking  <= 1'b1;
      row_done <= 1'b0;
      min_x    <= cx;
      max_x    <= cx;
    end else if (walking && !stall) begin
      if (at_end) begin
        walking  <= 1'b0;
        row_done <= 1'b1;
        last_row <= 1'b1;
      end else begin
        cx  <= nx;
        cy  <= ny;
        err <= nerr;
        if (y_step) begin
          // The new pixel opens the next row; it seeds that row's extent.
          walking  <= 1'b0;
          row_done <= 1'b1;
        end else begin
          if (nx < min_x) min_x <= nx;
          if (nx > max_x) max_x <= nx;
        end
      end
    end
  end

endmodule

// File: rtl/scanline_tri_fill.sv
// Rasterises one triangle into a left-to-right, top-to-bottom stream of
// filled pixel coordinates, clipped to the viewport, with valid/ready output.
//   clk_in, rst_in     : clock, synchronous active-high reset
//   start              : accept x0..y2 when busy=0
//   abort              : end the current triangle (done pulses next cycle)
//   x0,y0,x1,y1,x2,y2  : signed vertices, sampled on the accepted start only
//   x, y, valid, ready : registered pixel output with backpressure
//   busy               : triangle in progress
//   done               : one-cycle completion pulse
//   pixel_count        : pixels handshaken for the current/last triangle
module scanline_tri_fill
  import raster_pkg::*;
#(
  parameter int COORD_WIDTH = DEF_COORD_WIDTH,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int COUNT_WIDTH = 18
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start,
  input  logic                          abort,
  input  logic signed [COORD_WIDTH-1:0] x0,
  input  logic signed [COORD_WIDTH-1:0] y0,
  input  logic signed [COORD_WIDTH-1:0] x1,
  input  logic signed [COORD_WIDTH-1:0] y1,
  input  logic signed [COORD_WIDTH-1:0] x2,
  input  logic signed [COORD_WIDTH-1:0] y2,
  output logic signed [COORD_WIDTH-1:0] x,
  output logic signed [COORD_WIDTH-1:0] y,
  output logic                          valid,
  input  logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT_WIDTH-1:0]        pixel_count
);

  localparam int AW = COORD_WIDTH + 2;
  typedef logic signed [COORD_WIDTH-1:0] crd_t;
  typedef logic signed [AW-1:0]          wide_t;

  fill_state_t state;

  crd_t  cap_x [3], cap_y [3];   // vertices as accepted
  crd_t  v_x   [3], v_y   [3];   // vertices sorted by ascending y
  crd_t  srt_x [3], srt_y [3];
  crd_t  tmp_x, tmp_y;
  crd_t  hi_x;
  wide_t cur_y, span_min, span_max, row_min, row_max;
  logic  use_b, merge_q, adv_long_q, adv_short_q;
  int    row_min_i, row_max_i, cur_y_i, clip_lo, clip_hi;
  logic  span_empty, walk_complete, handshake;

  logic  long_done, long_last, short_done, short_last, short_sel_b;
  wide_t long_min, long_max, short_min, short_max;

  // Stable 3-element sort: strict compares keep equal-y vertices in order.
  always_comb begin
    srt_x = cap_x;
    srt_y = cap_y;
    tmp_x = '0;
    tmp_y = '0;
    if (srt_y[0] > srt_y[1]) begin
      tmp_x = srt_x[0]; tmp_y = srt_y[0];
      srt_x[0] = srt_x[1]; srt_y[0] = srt_y[1];
      srt_x[1] = tmp_x;    srt_y[1] = tmp_y;
    end
    if (srt_y[1] > srt_y[2]) begin
      tmp_x = srt_x[1]; tmp_y = srt_y[1];
      srt_x[1] = srt_x[2]; srt_y[1] = srt_y[2];
      srt_x[2] = tmp_x;    srt_y[2] = tmp_y;
    end
    if (srt_y[0] > srt_y[1]) begin
      tmp_x = srt_x[0]; tmp_y = srt_y[0];
      srt_x[0] = srt_x[1]; srt_y[0] = srt_y[1];
      srt_x[1] = tmp_x;    srt_y[1] = tmp_y;
    end
  end

  // The short-edge walker is reloaded with v1->v2 in SWITCH_EDGE.
  assign short_sel_b = (state == ST_SWITCH_EDGE);

  bresenham_edge_span #(.COORD_WIDTH(COORD_WIDTH)) u_long_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (state == ST_INIT_EDGES),
    .xa       (v_x[0]),
    .ya       (v_y[0]),
    .xb       (v_x[2]),
    .yb       (v_y[2]),
    .advance  (adv_long_q),
    .stall    (valid && !ready),
    .row_done (long_done),
    .min_x    (long_min),
    .max_x    (long_max),
    .last_row (long_last)
  );

  bresenham_edge_span #(.COORD_WIDTH(COORD_WIDTH)) u_short_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    ((state == ST_INIT_EDGES) || short_sel_b),
    .xa       (short_sel_b ? v_x[1] : v_x[0]),
    .ya       (short_sel_b ? v_y[1] : v_y[0]),
    .xb       (short_sel_b ? v_x[2] : v_x[1]),
    .yb       (short_sel_b ? v_y[2] : v_y[1]),
    .advance  (adv_short_q),
    .stall    (valid && !ready),
    .row_done (short_done),
    .min_x    (short_min),
    .max_x    (short_max),
    .last_row (short_last)
  );

  // Row extent over both walkers, merged with the v0->v1 part on row y1.
  always_comb begin
    row_min = (long_min < short_min) ? long_min : short_min;
    row_max = (long_max > short_max) ? long_max : short_max;
    if (merge_q) begin
      if (span_min < row_min) row_min = span_min;
      if (span_max > row_max) row_max = span_max;
    end
    row_min_i  = int'(row_min);
    row_max_i  = int'(row_max);
    cur_y_i    = int'(cur_y);
    clip_lo    = clamp_int(row_min_i, 0, SCREEN_W - 1);
    clip_hi    = clamp_int(row_max_i, 0, SCREEN_W - 1);
    span_empty = (cur_y_i < 0) || (cur_y_i >= SCREEN_H) ||
                 (row_max_i < 0) || (row_min_i >= SCREEN_W);
  end

  // Advance pulses are registered, so the walkers' row_done is stale on the
  // first WALK_ROW cycle; completion waits for the pulses to retire.
  assign walk_complete = (state == ST_WALK_ROW) && !adv_long_q && !adv_short_q &&
                         long_done && short_done;
  assign handshake     = valid && ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pixel_count <= '0;
      cur_y       <= '0;
      span_min    <= '0;
      span_max    <= '0;
      hi_x        <= '0;
      use_b       <= 1'b0;
      merge_q     <= 1'b0;
      adv_long_q  <= 1'b0;
      adv_short_q <= 1'b0;
      // NOTE: the vertex arrays are left out of reset on purpose; they are
      // always loaded on accept/SORT before anything reads them.
    end else begin
      adv_long_q  <= 1'b0;
      adv_short_q <= 1'b0;
      done        <= 1'b0;
      if (busy && abort) begin
        if (handshake) pixel_count <= pixel_count + COUNT_WIDTH'(1);
        valid <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cap_x       <= '{x0, x1, x2};
              cap_y       <= '{y0, y1, y2};
              busy        <= 1'b1;
              pixel_count <= '0;
              state       <= ST_SORT;
            end
          end
          ST_SORT: begin
            v_x   <= srt_x;
            v_y   <= srt_y;
            state <= ST_INIT_EDGES;
          end
          ST_INIT_EDGES: begin
            cur_y       <= AW'(v_y[0]);
            use_b       <= 1'b0;
            merge_q     <= 1'b0;
            adv_long_q  <= 1'b1;
            adv_short_q <= 1'b1;
            state       <= ST_WALK_ROW;
          end
          ST_WALK_ROW: begin
            if (walk_complete) begin
              if (!use_b && short_last) begin
                // Row y1: keep this extent and walk v1->v2 on the same row.
                span_min <= row_min;
                span_max <= row_max;
                merge_q  <= 1'b1;
                use_b    <= 1'b1;
                state    <= ST_SWITCH_EDGE;
              end else if (!span_empty) begin
                x     <= clip_lo[COORD_WIDTH-1:0];
                y     <= cur_y[COORD_WIDTH-1:0];
                hi_x  <= clip_hi[COORD_WIDTH-1:0];
                valid <= 1'b1;
                state <= ST_EMIT_SPAN;
              end else if (long_last) begin
                state <= ST_FINISH;
              end else begin
                cur_y       <= cur_y + AW'(1);
                merge_q     <= 1'b0;
                adv_long_q  <= 1'b1;
                adv_short_q <= 1'b1;
              end
            end
          end
          ST_SWITCH_EDGE: begin
            adv_short_q <= 1'b1;
            state       <= ST_WALK_ROW;
          end
          ST_EMIT_SPAN: begin
            if (handshake) begin
              pixel_count <= pixel_count + COUNT_WIDTH'(1);
              if (x == hi_x) begin
                valid <= 1'b0;
                if (long_last) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end else begin
                  cur_y       <= cur_y + AW'(1);
                  merge_q     <= 1'b0;
                  adv_long_q  <= 1'b1;
                  adv_short_q <= 1'b1;
                  state       <= ST_WALK_ROW;
                end
              end else begin
                x <= x + COORD_WIDTH'(1);
              end
            end
          end
          ST_FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/scanline_tri_fill.md
Name: scanline_tri_fill

Overview:
- Parametrised successor to the team's Bresenham triangle filler.
- Rasterises one triangle into a stream of filled-pixel coordinates, scanline by scanline.
- Adds viewport clipping, valid/ready output backpressure, an abort input and a pixel count.
- Sits between the vertex/transform stage and the framebuffer write port.

Parameters:
- COORD_WIDTH, 16: signed width of vertex coordinates and internal edge arithmetic.
- SCREEN_W, 320: viewport width; legal x range is [0, SCREEN_W-1].
- SCREEN_H, 240: viewport height; legal y range is [0, SCREEN_H-1].
- COUNT_WIDTH, 18: width of pixel_count.

Ports:
- clk_in  in  1  single clock.
- rst_in  in  1  synchronous active-high reset.
- start  in  1  accept the triangle when busy=0.
- abort  in  1  terminate the current triangle.
- x0,y0,x1,y1,x2,y2  in  COORD_WIDTH each, signed  vertices; sampled on the accepted start cycle only.
- x,y  out  COORD_WIDTH each, signed  pixel coordinate.
- valid  out  1  x,y hold a pixel.
- ready  in  1  consumer accepts the pixel when valid&&ready.
- busy  out  1  triangle in progress.
- done  out  1  one-cycle completion pulse.
- pixel_count  out  COUNT_WIDTH  pixels handshaken for the current/last triangle.

Behaviour:
- Reset: state IDLE; valid=0, busy=0, done=0, pixel_count=0; x,y=0. Reset mid-triangle discards all work.
- Start: accepted when start=1 && busy=0. busy=1 from the next cycle. start while busy is ignored.
- Coverage definition (golden model):
  - Each edge is walked from its lower-y vertex to its higher-y vertex with the standard all-octant integer Bresenham algorithm: dx=|xb-xa|, dy=-|yb-ya|, err=dx+dy, e2=2*err.
  - The filled set is, per row y, every x in [min, max] of all edge pixels on that row.
  - Each pixel is emitted exactly once.
- Sort: vertices are sorted by ascending y, ties keeping input order, in ≤3 cycles. The long edge is v0→v2; the short edges are v0→v1 then v1→v2.
- Row loop, for y = ysorted0 .. ysorted2:
  - Advance the long edge and the active short edge until each leaves row y, tracking min/max x per edge.
  - Span = [min, max] over both edges. On the row y==y1, the span also covers the v0→v1 pixels.
  - Pixels are emitted left to right.
- Clipping:
  - Rows with y<0 or y≥SCREEN_H are walked but emit nothing.
  - Spans are clamped to [0, SCREEN_W-1]; a span that is empty after clamping emits nothing.
  - Internal arithmetic uses COORD_WIDTH+2 bits; no overflow for any legal input.
- Handshake:
  - x,y,valid are registered.
  - While valid && !ready, x and y hold stable and the edge walkers stall.
  - Throughput is 1 pixel/cycle within a span with ready held at 1.
  - Inter-row gap ≤ edge steps on that row + 4 cycles.
- pixel_count: cleared on accept, incremented on each handshake, held after done.
- Done:
  - done pulses 1 cycle, the cycle after the last handshake. busy falls in the same cycle.
  - A triangle producing zero pixels (fully clipped) still pulses done, ≤ (rows walked × max edge steps) + 8 cycles after start.
- Degenerate cases: all-equal y gives a single row; all-equal vertices give one pixel.
- Abort (while busy):
  - Next cycle: valid=0, done pulses, busy=0; pixel_count holds.
  - A pixel handshaken in the abort cycle still counts.
  - abort while idle is ignored.
- FSM: IDLE → SORT → INIT_EDGES → WALK_ROW → EMIT_SPAN → (WALK_ROW | SWITCH_EDGE → WALK_ROW | FINISH) → IDLE.

Decomposition:
- Package raster_pkg holds: the fill state enum, the coordinate typedef (signed [COORD_WIDTH-1:0]), and a min/max clamp function.
- Sub-module bresenham_edge_span:
  - Start/advance/stall interface.
  - Walks one edge a row at a time and reports that row's min_x/max_x plus a last_row flag.
  - Instantiated twice; the short-edge instance is reloaded for v1→v2.

Test Plan:
- (0,0),(4,0),(0,4), ready=1 → rows 0..4 with spans [0,4],[0,3],[0,2],[0,1],[0,0]; pixel_count=15; single done pulse.
- (3,3),(3,3),(3,3) → exactly one pixel (3,3); then done.
- SCREEN_W=SCREEN_H=8, (-2,-2),(2,-2),(-2,2) → only (0,0) emitted, count=1. Then (20,20),(30,20),(20,30) → zero pixels, done still pulses, count=0.
- Triangle 1 with ready toggling by LFSR → identical ordered pixel list, x,y stable during stalls, no duplicates.
- Abort asserted after the 6th handshake of triangle 1 → valid drops next cycle, done pulses, count=6; a new start is accepted the following cycle.
- rst_in asserted mid-span → all outputs return to reset values next cycle; start while busy ignored.
